// File: rtl/generic_sram_arb_pkg.sv
// generic_sram_arb_pkg: shared types and helpers for the byte-enable SRAM arbiter
package generic_sram_arb_pkg;

    localparam int REQ_IDX_MAX_BITS = 4;

    function automatic int req_idx_bits(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef logic [REQ_IDX_MAX_BITS-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rsp_tag_t;

endpackage

// File: rtl/generic_sram_byte_en_if.sv
// generic_sram_byte_en_if: single-port byte-enable SRAM connection
interface generic_sram_byte_en_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
);
    logic                   write_en;
    logic                   read_en;
    logic [ADDR_BITS-1:0]   addr;
    logic [DATA_BITS/8-1:0] byte_en;
    logic [DATA_BITS-1:0]   write_data;
    logic [DATA_BITS-1:0]   read_data;

    modport sram_client (output write_en, read_en, addr, byte_en, write_data, input read_data);
    modport sram (input write_en, read_en, addr, byte_en, write_data, output read_data);
endinterface

// File: rtl/generic_sram_rr_arbiter.sv
// generic_sram_rr_arbiter: one-hot grant from a request vector; GENERIC_SRAM_ARB_FIXED_PRIO_EN selects lowest-index-wins
module generic_sram_rr_arbiter
    import generic_sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]               req,
    input  logic [req_idx_bits(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]               gnt
);
`ifdef GENERIC_SRAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;
    assign gnt = req & (~req + NUM_REQ'(1));
`else
    logic [NUM_REQ-1:0] hi;

    // Prefer the lowest requester at or above rr_ptr, otherwise wrap to the lowest overall
    always_comb begin
        hi  = req & ~((NUM_REQ'(1) << rr_ptr) - NUM_REQ'(1));
        gnt = (|hi) ? hi & (~hi + NUM_REQ'(1)) : req & (~req + NUM_REQ'(1));
    end
`endif
endmodule

// File: rtl/generic_sram_byte_en_arbiter.sv
// generic_sram_byte_en_arbiter: shares one byte-enable SRAM port among NUM_REQ requesters; GENERIC_SRAM_ARB_FIXED_PRIO_EN selects fixed priority
module generic_sram_byte_en_arbiter
    import generic_sram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32,
    parameter int READ_LATENCY  = 1,
    parameter int MAX_HOLD      = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic [NUM_REQ-1:0]                          req_write,
    input  logic [NUM_REQ-1:0]                          req_lock,
    input  logic [NUM_REQ-1:0][MEM_ADDR_BITS-1:0]       req_addr,
    input  logic [NUM_REQ-1:0][MEM_DATA_BITS/8-1:0]     req_byte_en,
    input  logic [NUM_REQ-1:0][MEM_DATA_BITS-1:0]       req_write_data,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    output logic [MEM_DATA_BITS-1:0]                    rsp_read_data,
    generic_sram_byte_en_if.sram_client                 sram_if
);
    localparam int IW = req_idx_bits(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic                           live;
    logic                           locked;
    logic                           miss;
    logic                           acc;
    logic [IW-1:0]                  rr_ptr;
    logic [IW-1:0]                  owner;
    logic [IW-1:0]                  win;
    logic [IW-1:0]                  nxt;
    logic [HW-1:0]                  hold_cnt;
    logic [HW-1:0]                  hold_nx;
    logic [NUM_REQ-1:0]             eff;
    logic [NUM_REQ-1:0]             gnt;
    rsp_tag_t [READ_LATENCY-1:0]    pipe;

    // Nothing is eligible in reset or the cycle after; while locked only the owner is
    assign eff = (live && !rst) ? (locked ? req_valid & (NUM_REQ'(1) << owner) : req_valid) : '0;

    generic_sram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (eff),
        .rr_ptr (rr_ptr),
        .gnt    (gnt)
    );

    // Encode the one-hot grant into the winner index
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) win = IW'(i);
    end

    assign acc     = |gnt;
    assign nxt     = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
    assign hold_nx = hold_cnt + HW'(1);

    assign req_ready          = gnt;
    assign sram_if.write_en   = acc && req_write[win];
    assign sram_if.read_en    = acc && !req_write[win];
    assign sram_if.addr       = acc ? req_addr[win] : '0;
    assign sram_if.byte_en    = acc ? req_byte_en[win] : '0;
    assign sram_if.write_data = acc ? req_write_data[win] : '0;

    // Lock ownership, hold counting, idle-owner release and round-robin pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            live     <= 1'b0;
            locked   <= 1'b0;
            miss     <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            live <= 1'b1;
            miss <= 1'b0;
            if (acc && req_lock[win] && hold_nx != HW'(MAX_HOLD)) begin
                locked   <= 1'b1;
                owner    <= win;
                hold_cnt <= hold_nx;
            end else if (acc) begin
                locked   <= 1'b0;
                hold_cnt <= '0;
                rr_ptr   <= nxt;
            end else if (locked && !req_valid[owner]) begin
                miss <= !miss;
                if (miss) begin
                    locked   <= 1'b0;
                    hold_cnt <= '0;
                end
            end
        end
    end

    // Read-return tags, one stage per SRAM latency cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: acc && !req_write[win], idx: req_idx_t'(win)};
            for (int k = 1; k < READ_LATENCY; k++)
                pipe[k] <= pipe[k-1];
        end
    end

    assign rsp_valid     = (!rst && pipe[READ_LATENCY-1].valid) ? NUM_REQ'(1) << pipe[READ_LATENCY-1].idx : '0;
    assign rsp_read_data = sram_if.read_data;
endmodule

// File: tb/tb_generic_sram_byte_en_arbiter.sv
// tb_generic_sram_byte_en_arbiter: vectors, corner sequences and randomized traffic against a behavioural model
module tb_generic_sram_byte_en_arbiter;
    localparam int N = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int L = 3;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    logic [N-1:0] v, w, lk, ready, rsp_valid;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][BW-1:0] be;
    logic [N-1:0][DW-1:0] wd;
    logic [DW-1:0] rdata;
    int n_chk = 0;
    int n_fail = 0;

    generic_sram_byte_en_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) sif ();

    generic_sram_byte_en_arbiter #(
        .NUM_REQ(N), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .READ_LATENCY(L), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(ready), .req_write(w), .req_lock(lk),
        .req_addr(addr), .req_byte_en(be), .req_write_data(wd),
        .rsp_valid(rsp_valid), .rsp_read_data(rdata),
        .sram_if(sif)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pre(input int a);
        return (a >= 256) ? 32'h1357_0000 + 32'(a * 3) : '0;
    endfunction

    // SRAM macro with L-cycle registered read
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rd [L];
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= pre(a);
        end else begin
            for (int b = 0; b < BW; b++)
                if (sif.write_en && sif.byte_en[b]) mem[sif.addr][b*8 +: 8] <= sif.write_data[b*8 +: 8];
        end
        rd[0] <= sif.read_en ? mem[sif.addr] : 32'hDEAD_BEEF;
        for (int k = 1; k < L; k++) rd[k] <= rd[k-1];
    end
    assign sif.read_data = rd[L-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: arbitration by plain search, expected returns in a queue
    typedef struct {
        int due;
        int idx;
        logic [DW-1:0] data;
    } ret_t;
    ret_t q[$];
    ret_t r;
    logic [DW-1:0] shadow [1 << AW];
    int ptr, own, beats, miss, cyc, g, j;
    bit alive;
    logic [N-1:0] exp_rsp;
    logic [DW-1:0] exp_data;

    initial begin
        ptr = 0; own = -1; beats = 0; miss = 0; cyc = 0; alive = 0;
        forever begin
            @(negedge clk);
            if (preload) for (int a = 0; a < (1 << AW); a++) shadow[a] = pre(a);
            g = -1;
            if (alive && !rst) begin
                if (own >= 0) begin
                    if (v[own]) g = own;
                end else begin
                    for (int k = 0; k < N; k++) begin
`ifdef GENERIC_SRAM_ARB_FIXED_PRIO_EN
                        j = k;
`else
                        j = (ptr + k) % N;
`endif
                        if (g < 0 && v[j]) g = j;
                    end
                end
            end
            chk("m_ready", ready, (g >= 0) ? N'(1) << g : '0);
            chk("m_write_en", sif.write_en, (g >= 0) ? w[g] : 1'b0);
            chk("m_read_en", sif.read_en, (g >= 0) ? !w[g] : 1'b0);
            chk("m_addr", sif.addr, (g >= 0) ? addr[g] : '0);
            chk("m_byte_en", sif.byte_en, (g >= 0) ? be[g] : '0);
            chk("m_write_data", sif.write_data, (g >= 0) ? wd[g] : '0);
            exp_rsp = '0;
            exp_data = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (!rst) begin
                    exp_rsp = N'(1) << q[0].idx;
                    exp_data = q[0].data;
                end
                void'(q.pop_front());
            end
            chk("m_rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != '0) chk("m_rsp_data", rdata, exp_data);
            if (rst) begin
                ptr = 0; own = -1; beats = 0; miss = 0; alive = 0;
                q.delete();
            end else begin
                alive = 1;
                if (g >= 0) begin
                    miss = 0;
                    if (w[g]) begin
                        for (int b = 0; b < BW; b++)
                            if (be[g][b]) shadow[addr[g]][b*8 +: 8] = wd[g][b*8 +: 8];
                    end else begin
                        r.due = cyc + L;
                        r.idx = g;
                        r.data = shadow[addr[g]];
                        q.push_back(r);
                    end
                    if (lk[g] && beats + 1 < MAX_HOLD) begin
                        own = g;
                        beats++;
                    end else begin
                        own = -1;
                        beats = 0;
                        ptr = (g + 1) % N;
                    end
                end else if (own >= 0 && !v[own]) begin
                    miss++;
                    if (miss == 2) begin
                        own = -1; beats = 0; miss = 0;
                    end
                end
            end
            cyc++;
        end
    end

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl [12];

    initial begin
        tbl = '{'{4'hF, 4'h0}, '{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8}, '{4'hF, 4'h1},
                '{4'hA, 4'h2}, '{4'h9, 4'h8}, '{4'h6, 4'h2}, '{4'h0, 4'h0}, '{4'h3, 4'h1}, '{4'h1, 4'h1}};
        preload = 1; rst = 1; v = '1; w = '0; lk = '0; addr = '0; be = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1 preload = 0;
        @(negedge clk);
        chk("reset_ready", ready, '0);
        chk("reset_rsp_valid", rsp_valid, '0);
        chk("reset_write_en", sif.write_en, 1'b0);
        chk("reset_read_en", sif.read_en, 1'b0);
        tick();
        rst = 0;
        for (int i = 0; i < N; i++) addr[i] = AW'(10'h100 + i * 5);
`ifdef GENERIC_SRAM_ARB_FIXED_PRIO_EN
        v = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("fixed_prio", ready, (i == 0) ? 4'b0000 : 4'b0001);
            tick();
        end
`else
        for (int i = 0; i < 12; i++) begin
            v = tbl[i].v;
            @(negedge clk);
            chk("rr_table", ready, tbl[i].exp);
            tick();
        end
`endif
        v = 4'b0010; w = 4'b0010; addr[1] = 10'h10; be[1] = 4'h3; wd[1] = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("wr_ready", ready, 4'b0010);
        chk("wr_en", sif.write_en, 1'b1);
        chk("wr_addr", sif.addr, 10'h10);
        chk("wr_byte_en", sif.byte_en, 4'h3);
        chk("wr_data", sif.write_data, 32'hA5A5_A5A5);
        tick();
        w = '0;
        @(negedge clk);
        chk("rd_en", sif.read_en, 1'b1);
        chk("rd_ready", ready, 4'b0010);
        tick();
        v = '0;
        repeat (L - 1) tick();
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 4'b0010);
        chk("rd_rsp_data", rdata, 32'h0000_A5A5);
        tick();
`ifndef GENERIC_SRAM_ARB_FIXED_PRIO_EN
        v = 4'b1101; lk = 4'b0100;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            chk("lock_hold", ready, 4'b0100);
            tick();
        end
        @(negedge clk); chk("lock_rotate3", ready, 4'b1000); tick();
        @(negedge clk); chk("lock_rotate0", ready, 4'b0001); tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("lock_regain", ready, 4'b0100); tick();
        end
        v = 4'b1001;
        @(negedge clk); chk("drop1_nogrant", ready, 4'b0000); tick();
        v = 4'b1101;
        @(negedge clk); chk("drop1_held", ready, 4'b0100); tick();
        v = 4'b1001;
        @(negedge clk); chk("drop2_first", ready, 4'b0000); tick();
        @(negedge clk); chk("drop2_second", ready, 4'b0000); tick();
        @(negedge clk); chk("drop2_others3", ready, 4'b1000); tick();
        @(negedge clk); chk("drop2_others0", ready, 4'b0001); tick();
        v = '0; lk = '0;
        tick();
`endif
        v = 4'b0001;
        @(negedge clk); chk("inflight_a", ready, 4'b0001); tick();
        v = 4'b0010;
        @(negedge clk); chk("inflight_b", ready, 4'b0010); tick();
        v = '0; rst = 1;
        @(negedge clk); chk("rst_mid_rsp", rsp_valid, '0); tick();
        rst = 0; v = '1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, '0);
`ifdef GENERIC_SRAM_ARB_FIXED_PRIO_EN
            chk("post_rst_ready", ready, (i == 0) ? 4'b0000 : 4'b0001);
`else
            chk("post_rst_ready", ready, (i == 0) ? 4'b0000 : N'(1) << (i - 1));
`endif
            tick();
        end
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            v = N'($urandom | $urandom);
            w = N'($urandom);
            lk = N'($urandom | $urandom);
            for (int i = 0; i < N; i++) begin
                addr[i] = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
                be[i] = BW'($urandom);
                wd[i] = $urandom;
            end
            tick();
        end
        rst = 0; v = '0; lk = '0;
        repeat (L + 2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
